// File: rtl/reg_wb_unit.sv
// Merges a fast execute write port and a buffered slow write port onto one registered RF write port.
// Latency 1 cycle for execute writes. The slow side is backpressured by lsu_ready whenever the buffer is full.
module reg_wb_unit #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_wr_en,
  input  logic [4:0]  ex_wr_addr,
  input  logic [31:0] ex_wr_data,
  input  logic        lsu_valid,
  output logic        lsu_ready,
  input  logic [4:0]  lsu_addr,
  input  logic [31:0] lsu_data,
  output logic        wr_en,
  output logic [4:0]  wr_addr,
  output logic [31:0] wr_data,
  input  logic [4:0]  rs1_addr,
  input  logic [4:0]  rs2_addr,
  output logic        hazard1,
  output logic        hazard2,
  output logic        busy
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wb_ent_t;

  wb_ent_t          ent [DEPTH];
  logic [DEPTH-1:0] kill;
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic [CW-1:0]    count;

  logic             ex_acc;
  logic             pop;
  logic             push;
  logic             push_killed;
  logic [DEPTH-1:0] live;
  logic [DEPTH-1:0] ex_match;

  // Address 0 requests are treated as absent, so they never block a pop.
  assign ex_acc      = ex_wr_en && (ex_wr_addr != 5'd0);
  assign lsu_ready   = (count < CW'(DEPTH));
  assign push        = lsu_valid && lsu_ready && (lsu_addr != 5'd0);
  assign pop         = !ex_acc && (count != '0);
  assign push_killed = ex_acc && (lsu_addr == ex_wr_addr);
  assign busy        = (count != '0);

  // A slot is live when its distance from head is below the occupancy.
  always_comb begin
    live     = '0;
    ex_match = '0;
    for (int i = 0; i < DEPTH; i++) begin
      live[i]     = ({1'b0, PW'(i) - head} < count);
      ex_match[i] = live[i] && (ent[i].addr == ex_wr_addr);
    end
  end

  always_comb begin
    hazard1 = 1'b0;
    hazard2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (live[i] && !kill[i]) begin
        if (ent[i].addr == rs1_addr) hazard1 = 1'b1;
        if (ent[i].addr == rs2_addr) hazard2 = 1'b1;
      end
    end
    if (rs1_addr == 5'd0) hazard1 = 1'b0;
    if (rs2_addr == 5'd0) hazard2 = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      kill    <= '0;
      wr_en   <= 1'b0;
      wr_addr <= 5'd0;
      wr_data <= 32'd0;
    end else begin
      // Newer execute write supersedes every older buffered write to the same register.
      if (ex_acc) kill <= kill | ex_match;
      // Tail is never live on a push (buffer not full), so this bit overrides the line above.
      if (push) kill[tail] <= push_killed;
      if (pop)  head <= head + PW'(1);
      if (push) tail <= tail + PW'(1);
      count <= count + CW'(push) - CW'(pop);

      if (ex_acc) begin
        wr_en   <= 1'b1;
        wr_addr <= ex_wr_addr;
        wr_data <= ex_wr_data;
      end else if (pop && !kill[head]) begin
        wr_en   <= 1'b1;
        wr_addr <= ent[head].addr;
        wr_data <= ent[head].data;
      end else begin
        wr_en   <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) ent[tail] <= '{addr: lsu_addr, data: lsu_data};
  end

endmodule

// File: tb/tb_reg_wb_unit.sv
// Directed and random checks of reg_wb_unit against a queue-based reference model.
module tb_reg_wb_unit;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ex_wr_en = 1'b0;
  logic [4:0]  ex_wr_addr = '0;
  logic [31:0] ex_wr_data = '0;
  logic        lsu_valid = 1'b0;
  logic        lsu_ready;
  logic [4:0]  lsu_addr = '0;
  logic [31:0] lsu_data = '0;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [4:0]  rs1_addr = '0;
  logic [4:0]  rs2_addr = '0;
  logic        hazard1;
  logic        hazard2;
  logic        busy;

  reg_wb_unit #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_wr_en(ex_wr_en), .ex_wr_addr(ex_wr_addr), .ex_wr_data(ex_wr_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_addr(lsu_addr), .lsu_data(lsu_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .hazard1(hazard1), .hazard2(hazard2), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    bit          kill;
  } ment_t;

  ment_t       q[$];
  logic        m_en;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  int          tests = 0;
  int          fails = 0;
  int          rf_writes_7;
  logic [31:0] rf_last_7;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_hazard(input logic [4:0] rs);
    if (rs == 5'd0) return 1'b0;
    foreach (q[i]) if (!q[i].kill && q[i].addr == rs) return 1'b1;
    return 1'b0;
  endfunction

  // One clock: drive at posedge+1, check combinational outputs, then the registered write after the edge.
  task automatic step(input logic xe, input logic [4:0] xa, input logic [31:0] xd,
                      input logic lv, input logic [4:0] la, input logic [31:0] ld,
                      input logic [4:0] r1, input logic [4:0] r2);
    bit    ex_acc, pushed;
    ment_t e;
    ex_wr_en = xe; ex_wr_addr = xa; ex_wr_data = xd;
    lsu_valid = lv; lsu_addr = la; lsu_data = ld;
    rs1_addr = r1; rs2_addr = r2;
    #1;
    chk("lsu_ready", 32'(lsu_ready), 32'(q.size() < DEPTH));
    chk("busy",      32'(busy),      32'(q.size() != 0));
    chk("hazard1",   32'(hazard1),   32'(m_hazard(r1)));
    chk("hazard2",   32'(hazard2),   32'(m_hazard(r2)));
    ex_acc = xe && (xa != 5'd0);
    pushed = lv && (q.size() < DEPTH) && (la != 5'd0);
    m_en = 1'b0;
    if (ex_acc) begin
      foreach (q[i]) if (q[i].addr == xa) q[i].kill = 1'b1;
      m_en = 1'b1; m_addr = xa; m_data = xd;
    end else if (q.size() > 0) begin
      e = q.pop_front();
      if (!e.kill) begin m_en = 1'b1; m_addr = e.addr; m_data = e.data; end
    end
    if (pushed) q.push_back('{addr: la, data: ld, kill: ex_acc && (xa == la)});
    @(posedge clk);
    #1;
    chk("wr_en",   32'(wr_en), 32'(m_en));
    chk("wr_addr", 32'(wr_addr), 32'(m_addr));
    chk("wr_data", wr_data, m_data);
    if (wr_en && wr_addr == 5'd7) begin rf_writes_7++; rf_last_7 = wr_data; end
  endtask

  task automatic idle(input logic [4:0] r1, input logic [4:0] r2);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, r1, r2);
  endtask

  // Reset asserted mid-cycle: outputs must clear without waiting for a clock edge.
  task automatic do_reset(input logic [4:0] r1, input logic [4:0] r2);
    ex_wr_en = 1'b0; lsu_valid = 1'b0; rs1_addr = r1; rs2_addr = r2;
    rst_n = 1'b0;
    #1;
    q.delete();
    m_en = 1'b0; m_addr = 5'd0; m_data = 32'd0;
    chk("rst_wr_en",     32'(wr_en), 32'd0);
    chk("rst_wr_addr",   32'(wr_addr), 32'd0);
    chk("rst_wr_data",   wr_data, 32'd0);
    chk("rst_busy",      32'(busy), 32'd0);
    chk("rst_lsu_ready", 32'(lsu_ready), 32'd1);
    chk("rst_hazard1",   32'(hazard1), 32'd0);
    chk("rst_hazard2",   32'(hazard2), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rf_writes_7 = 0;
    rf_last_7 = '0;
    @(posedge clk);
    #1;
    do_reset(5'd5, 5'd10);

    // Single execute write appears one cycle later.
    step(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'd0, 5'd5, 5'd0);
    idle(5'd5, 5'd0);

    // Fill the buffer while execute writes hog the port, then drain in order.
    for (int i = 0; i < 4; i++)
      step(1'b1, 5'd3, 32'h300 + 32'(i), 1'b1, 5'(10 + i), 32'hA0 + 32'(i), 5'd10, 5'd13);
    step(1'b1, 5'd3, 32'h399, 1'b1, 5'd14, 32'hEE, 5'd12, 5'd14);
    for (int i = 0; i < 4; i++) idle(5'd10, 5'd13);
    idle(5'd10, 5'd13);

    // Buffered x7 superseded by a newer execute write: the stale value must never reach the RF.
    rf_writes_7 = 0;
    step(1'b1, 5'd4, 32'h4, 1'b1, 5'd7, 32'hAAAA, 5'd7, 5'd0);
    step(1'b1, 5'd4, 32'h5, 1'b0, 5'd0, 32'd0, 5'd7, 5'd0);
    step(1'b1, 5'd7, 32'hBBBB, 1'b0, 5'd0, 32'd0, 5'd7, 5'd0);
    idle(5'd7, 5'd0);
    idle(5'd7, 5'd0);
    chk("x7_writes", 32'(rf_writes_7), 32'd1);
    chk("x7_value",  rf_last_7, 32'hBBBB);

    // Same-cycle execute and slow write to x9.
    step(1'b1, 5'd9, 32'd1, 1'b1, 5'd9, 32'd2, 5'd9, 5'd9);
    idle(5'd9, 5'd0);
    idle(5'd9, 5'd0);

    // Address-zero requests on both sides, then an ex addr-0 cycle that lets a pending entry pop.
    step(1'b1, 5'd0, 32'h55, 1'b1, 5'd0, 32'h66, 5'd0, 5'd0);
    step(1'b1, 5'd2, 32'h22, 1'b1, 5'd6, 32'h66, 5'd6, 5'd0);
    step(1'b1, 5'd0, 32'h77, 1'b0, 5'd0, 32'd0, 5'd6, 5'd0);
    idle(5'd6, 5'd0);

    // Two entries pending when reset hits: neither may be written afterwards.
    step(1'b1, 5'd1, 32'h11, 1'b1, 5'd20, 32'h2020, 5'd20, 5'd21);
    step(1'b1, 5'd1, 32'h12, 1'b1, 5'd21, 32'h2121, 5'd20, 5'd21);
    do_reset(5'd20, 5'd21);
    for (int i = 0; i < 3; i++) idle(5'd20, 5'd21);

    // Random traffic on a narrow address range to force collisions and kills.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 99) == 0) do_reset(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      step(1'($urandom_range(0, 99) < 45), 5'($urandom_range(0, 7)), $urandom,
           1'($urandom_range(0, 99) < 60), 5'($urandom_range(0, 7)), $urandom,
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end
    for (int i = 0; i < DEPTH + 1; i++) idle(5'd1, 5'd2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
